// File: rtl/prio_enc_queue_if.sv
// prio_enc_queue_if: request/grant bundle for prio_enc_queue.
//   req, mask  : request lines and per-line selection disable (source side)
//   out_valid, out_idx, out_ready : winner index handshake
//   pend       : pending register, exposed for software visibility
//   ovf, ovf_clr : sticky overflow flag and its synchronous clear
// master = the encoder, slave = the surrounding sources/consumer.
interface prio_enc_queue_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         out_ready;
    logic [N-1:0] pend;
    logic         ovf;
    logic         ovf_clr;

    modport master (
        input  req, mask, out_ready, ovf_clr,
        output out_valid, out_idx, pend, ovf
    );

    modport slave (
        output req, mask, out_ready, ovf_clr,
        input  out_valid, out_idx, pend, ovf
    );
endinterface

// File: rtl/prio_enc_queue.sv
// prio_enc_queue: registered priority encoder with sticky pending requests.
// Requests are captured into a pending register; the winning eligible line
// is presented as an encoded index on a valid/ready port and its pending
// bit is cleared when the index is accepted.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (acts as a flush)
//   bus : prio_enc_queue_if.master (req, mask, out_valid, out_idx,
//         out_ready, pend, ovf, ovf_clr)
// Parameters: N request lines, W index width, RR = 0 fixed priority
// (highest index wins), RR = 1 round-robin.
module prio_enc_queue #(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter int RR = 0
) (
    input  logic             clk,
    input  logic             rst,
    prio_enc_queue_if.master bus
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [N-1:0] pend_q;
    logic [N-1:0] clr;
    logic [N-1:0] pend_next;
    logic [N-1:0] elig;
    logic         valid_q;
    logic [W-1:0] idx_q;
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_next;
    logic [W-1:0] scan_start;
    logic [W-1:0] win;
    logic         ovf_q;
    logic         xfer;
    logic         load;
    logic         ovf_set;

    assign xfer = valid_q & bus.out_ready;
    // The output register only reloads when empty or when the consumer
    // takes the current index, so a held index is never overtaken.
    assign load = ~valid_q | xfer;

    always_comb begin
        clr = '0;
        if (xfer) begin
            clr[idx_q] = 1'b1;
        end
    end

    // A request on the line being cleared re-sets it.
    assign pend_next = (pend_q & ~clr) | bus.req;
    assign elig      = pend_next & ~bus.mask;
    assign ovf_set   = |(bus.req & pend_q & ~clr);

    always_comb begin
        ptr_next = ptr_q;
        if (xfer) begin
            ptr_next = (idx_q == '0) ? LAST : idx_q - 1'b1;
        end
    end

    // Both modes are a descending wrap-around scan; fixed priority simply
    // always starts at the top line. Round-robin starts from the pointer as
    // updated by this edge's transfer so back-to-back grants rotate.
    assign scan_start = (RR != 0) ? ptr_next : LAST;

    always_comb begin
        int unsigned s;
        int unsigned j;
        logic        found;
        win   = '0;
        found = 1'b0;
        s     = 32'(scan_start);
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (k <= s) begin
                j = s - k;
            end else begin
                j = s + N - k;
            end
            if (!found && elig[W'(j)]) begin
                win   = W'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= LAST;
        end else begin
            pend_q <= pend_next;
            ptr_q  <= ptr_next;
            if (load) begin
                valid_q <= |elig;
                idx_q   <= win;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.pend      = pend_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_prio_enc_queue.sv
// tb_prio_enc_queue: bench for prio_enc_queue with N=4, one fixed-priority
// and one round-robin instance driven by the same stimulus. A reference
// model predicts each cycle's visible state into a queue; a negedge monitor
// pops and compares. Directed scenarios add fixed expected values.
module tb_prio_enc_queue;
    typedef struct {
        bit       v;
        int       idx;
        bit [3:0] p;
        bit       ov;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       out_ready;
    logic       ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];

    // reference model state: index 0 = fixed priority, 1 = round-robin
    bit [3:0] m_p[2];
    bit       m_v[2];
    int       m_idx[2];
    bit       m_ov[2];
    int       m_ptr;

    prio_enc_queue_if #(.N(4)) b0 ();
    prio_enc_queue_if #(.N(4)) b1 ();

    assign b0.req = req;
    assign b0.mask = mask;
    assign b0.out_ready = out_ready;
    assign b0.ovf_clr = ovf_clr;
    assign b1.req = req;
    assign b1.mask = mask;
    assign b1.out_ready = out_ready;
    assign b1.ovf_clr = ovf_clr;

    prio_enc_queue #(.N(4), .RR(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.master));
    prio_enc_queue #(.N(4), .RR(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int pick(input bit rr, input bit [3:0] el, input int ptr);
        int j;
        for (int s = 0; s < 4; s++) begin
            j = rr ? (ptr - s + 4) % 4 : 3 - s;
            if (el[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input int k);
        bit [3:0] np;
        bit       xfer;
        bit       hit;
        bit       taken;
        int       w;
        xfer = m_v[k] && out_ready;
        hit  = 1'b0;
        for (int j = 0; j < 4; j++) begin
            taken = xfer && (m_idx[k] == j);
            np[j] = (m_p[k][j] && !taken) || req[j];
            if (req[j] && m_p[k][j] && !taken) hit = 1'b1;
        end
        if (hit) m_ov[k] = 1'b1;
        else if (ovf_clr) m_ov[k] = 1'b0;
        if (k == 1 && xfer) m_ptr = (m_idx[1] + 3) % 4;
        if (!m_v[k] || xfer) begin
            w = pick(k == 1, np & ~mask, m_ptr);
            m_v[k]   = (w >= 0);
            m_idx[k] = (w >= 0) ? w : 0;
        end
        m_p[k] = np;
    endtask

    function automatic exp_t snap(input int k);
        exp_t e;
        e.v = m_v[k];
        e.idx = m_idx[k];
        e.p = m_p[k];
        e.ov = m_ov[k];
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_p[k] = '0;
                m_v[k] = 1'b0;
                m_idx[k] = 0;
                m_ov[k] = 1'b0;
            end
            m_ptr = 3;
            q0.delete();
            q1.delete();
        end else begin
            model_step(0);
            model_step(1);
        end
        q0.push_back(snap(0));
        q1.push_back(snap(1));
    end

    task automatic cmp(input string tag, input exp_t e, input int v, input int idx,
                       input int p, input int ov);
        chk({tag, ".out_valid"}, v, int'(e.v));
        chk({tag, ".out_idx"}, idx, e.idx);
        chk({tag, ".pend"}, p, int'(e.p));
        chk({tag, ".ovf"}, ov, int'(e.ov));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() == 0) begin
            chk("fixed.no_expectation", 0, 1);
        end else begin
            e = q0.pop_front();
            cmp("fixed", e, int'(b0.out_valid), int'(b0.out_idx), int'(b0.pend), int'(b0.ovf));
        end
        if (q1.size() == 0) begin
            chk("rr.no_expectation", 0, 1);
        end else begin
            e = q1.pop_front();
            cmp("rr", e, int'(b1.out_valid), int'(b1.out_idx), int'(b1.pend), int'(b1.ovf));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".fixed_valid"}, int'(b0.out_valid), 0);
        chk({tag, ".fixed_idx"}, int'(b0.out_idx), 0);
        chk({tag, ".fixed_pend"}, int'(b0.pend), 0);
        chk({tag, ".fixed_ovf"}, int'(b0.ovf), 0);
        chk({tag, ".rr_valid"}, int'(b1.out_valid), 0);
        chk({tag, ".rr_pend"}, int'(b1.pend), 0);
        chk({tag, ".rr_ovf"}, int'(b1.ovf), 0);
    endtask

    initial begin
        int rr_seq[6];
        rr_seq = '{3, 2, 1, 0, 3, 2};
        rst = 1'b1;
        req = '0;
        mask = '0;
        out_ready = 1'b0;
        ovf_clr = 1'b0;
        #2 chk_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // two requests in one pulse drain highest first
        req = 4'b0101;
        out_ready = 1'b1;
        cyc();
        req = '0;
        chk("pulse.first", int'(b0.out_idx), 2);
        chk("pulse.first_valid", int'(b0.out_valid), 1);
        cyc();
        chk("pulse.second", int'(b0.out_idx), 0);
        cyc();
        chk("pulse.idle_valid", int'(b0.out_valid), 0);
        chk("pulse.idle_pend", int'(b0.pend), 0);

        // held index is not overtaken by a later higher request
        out_ready = 1'b0;
        req = 4'b0010;
        cyc();
        req = 4'b1000;
        cyc();
        req = '0;
        cyc();
        chk("hold.idx", int'(b0.out_idx), 1);
        out_ready = 1'b1;
        cyc();
        chk("hold.next", int'(b0.out_idx), 3);
        cyc();

        // rotation vs fixed with all lines held
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rotate.rr", int'(b1.out_idx), rr_seq[i]);
            chk("rotate.fixed", int'(b0.out_idx), 3);
        end
        req = '0;
        repeat (5) cyc();

        // masked line keeps its pending bit
        do_reset();
        mask = 4'b1000;
        req = 4'b1001;
        cyc();
        req = '0;
        chk("mask.grant", int'(b0.out_idx), 0);
        cyc();
        chk("mask.pend", int'(b0.pend), 4'b1000);
        chk("mask.idle", int'(b0.out_valid), 0);
        mask = '0;
        cyc();
        chk("mask.release", int'(b0.out_idx), 3);
        chk("mask.release_valid", int'(b0.out_valid), 1);
        cyc();

        // overflow set, clear, and set winning over clear
        out_ready = 1'b0;
        req = 4'b0010;
        repeat (3) cyc();
        chk("ovf.set", int'(b0.ovf), 1);
        req = '0;
        ovf_clr = 1'b1;
        cyc();
        chk("ovf.clear", int'(b0.ovf), 0);
        req = 4'b0010;
        cyc();
        chk("ovf.set_wins", int'(b0.ovf), 1);
        req = '0;
        ovf_clr = 1'b0;

        // asynchronous flush mid-cycle
        req = 4'b0100;
        cyc();
        req = '0;
        chk("flush.pre_pend", int'(b0.pend), 4'b0110);
        chk("flush.pre_valid", int'(b0.out_valid), 1);
        #3 rst = 1'b1;
        #1 chk_zero("flush");
        @(posedge clk);
        #3 rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            cyc();
        end
        req = '0;
        mask = '0;
        out_ready = 1'b1;
        ovf_clr = 1'b0;
        repeat (6) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prio_enc_queue.md
Name: prio_enc_queue

Overview:
- Parametrised, registered successor to the 4:2 combinational priority encoder.
- Captures N request lines into a sticky pending register.
- Presents the encoded index of the winning pending request on a valid/ready output port.
- Clears each request on acceptance. Supports fixed-priority (MSB wins) and round-robin modes.
- Sits between interrupt/event sources and a single consumer (sequencer or CPU-side handler).

Parameters:
- N, 8, number of request lines (N >= 2).
- W, $clog2(N), width of encoded index.
- RR, 0, priority mode: 0 = fixed (highest index wins), 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request lines, sampled every clock edge; level-high sets the pending bit.
- mask  input  N  1 = line disabled for selection; the pending bit is still recorded.
- out_valid  output  1  out_idx holds a valid winning index.
- out_idx  output  W  encoded index of the winner.
- out_ready  input  1  consumer accepts the current index.
- pend  output  N  pending register, for software visibility.
- ovf  output  1  sticky: a request arrived on a line already pending.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst=1): pend=0, out_valid=0, out_idx=0, ovf=0, RR pointer=N-1. All outputs are held at these values while rst is high.
- Handshake: a transfer occurs at an edge where out_valid=1 and out_ready=1. The clear vector clr is one-hot at out_idx on a transfer, otherwise 0.
- Pending update each edge: pend <= (pend & ~clr) | req.
  - A req bit set on the same line being cleared in that cycle re-sets the bit (set wins).
- Eligible vector: elig = pend_next & ~mask, where pend_next is the value loaded above.
- Output register load condition: out_valid=0 or a transfer occurs. On load:
  - out_valid <= |elig.
  - out_idx <= winner(elig), or 0 if elig is empty.
- Output stability: while out_valid=1 and out_ready=0, out_idx and out_valid hold even if higher-priority requests arrive or mask changes.
- Latency: req high before edge k, with the output idle, gives out_valid=1 after edge k (1 cycle). Back-to-back grants are possible with out_ready held high; throughput is one index per cycle.
- Fixed mode (RR=0): the winner is the highest set index. This matches the 4'b1xxx -> 11 truth table generalised to N.
- Round-robin mode (RR=1):
  - Scan descending from ptr, wrapping N-1 after 0; the first set bit wins.
  - On a transfer, ptr <= (out_idx==0) ? N-1 : out_idx-1.
  - ptr is unchanged otherwise.
- All-zero input: out_valid=0, out_idx=0. No error state; this replaces the old $display default.
- ovf:
  - Set at an edge where req[j]=1, pend[j]=1, and clr[j]=0 for any j.
  - ovf_clr=1 clears it. Simultaneous set and clear: set wins.
- Masked pending lines keep their bit. Such a line becomes eligible on the first load-condition edge after its mask bit is cleared.
- Reset mid-operation: an in-flight valid is dropped and pending state is lost. The consumer must treat rst as a flush.

Test Plan:
- N=4, RR=0: pulse req=4'b0101 for one cycle, out_ready=1 -> idx 2 then 0 on consecutive cycles, then out_valid=0; pend returns to 0.
- N=4, RR=0, out_ready=0: req=4'b0010, then a cycle later req=4'b1000 -> out_idx stays 1 until out_ready=1. The next grant is 3.
- N=4, RR=1, req held at 4'b1111, out_ready=1 -> grant sequence 3,2,1,0,3,2 (rotation). RR=0 with the same stimulus -> 3 every cycle.
- mask=4'b1000, req=4'b1001 pulse -> grant 0 only; pend=4'b1000 remains. Clear mask -> grant 3 the next cycle.
- req[1] held with out_ready=0 for 3 cycles -> ovf=1. Pulse ovf_clr -> ovf=0 the next cycle. ovf_clr together with a new overflow -> ovf stays 1.
- Assert rst asynchronously mid-clock while out_valid=1, pend=4'b0110 -> out_valid, out_idx, pend, and ovf are 0 immediately, before the next clk edge.
